mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have a single clock; reset SHALL be synchronous and active-low.
REQ-002 Parameter AW SHALL be the address width, default 32.
REQ-003 Parameter DW SHALL be the data width, default 32, with DW/8 byte-mask bits.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 m0_addr / m1_addr  in  AW  requester byte address.
REQ-007 m0_rstrb / m1_rstrb  in  1  read request.
REQ-008 m0_wdata / m1_wdata  in  DW  write data.
REQ-009 m0_wmask / m1_wmask  in  DW/8  byte write enables; any bit set means a write request.
REQ-010 m0_ready / m1_ready  out  1  request accepted this cycle.
REQ-011 m0_rdata / m1_rdata  out  DW  read data.
REQ-012 m0_rvalid / m1_rvalid  out  1  one-cycle pulse marking valid read data.
REQ-013 s_addr, s_rstrb, s_wdata, s_wmask  out  AW/1/DW/DW/8  shared memory port.
REQ-014 s_rdata  in  DW  memory read data, registered one cycle after s_rstrb.

Function
REQ-015 A requester SHALL be requesting when rstrb is 1 or wmask is nonzero.
REQ-016 A requester SHALL hold addr, wdata, wmask and rstrb stable until its ready pulses.
REQ-017 The state machine SHALL have two states: IDLE and RDATA.
REQ-018 In IDLE with at least one requester, the block SHALL grant exactly one requester combinationally in that cycle.
REQ-019 In the grant cycle, the block SHALL drive s_* from the granted requester and assert its ready for one cycle.
REQ-020 A granted write (rstrb=0) SHALL complete in the grant cycle; the state SHALL stay IDLE, so back-to-back writes run at one per cycle.
REQ-021 A granted read SHALL move the state IDLE->RDATA and register the grant index.
REQ-022 In RDATA, the block SHALL route s_rdata to the registered requester with rvalid=1, grant nothing, and return to IDLE.
REQ-023 A request carrying both rstrb and a nonzero wmask SHALL forward both to the memory port and SHALL take the read path (RDATA follows).
REQ-024 Outside a grant cycle, s_rstrb, s_wmask, s_addr and s_wdata SHALL be 0.
REQ-025 m*_rdata SHALL be s_rdata when that requester's rvalid is 1, and 0 otherwise.
REQ-026 A requester not granted SHALL see ready=0 and SHALL keep requesting; no request is dropped.
REQ-027 Arbitration under simultaneous requests SHALL follow REQ-033/REQ-034.
REQ-028 With a single requester active, that requester SHALL be granted in every IDLE cycle, regardless of arbitration history.

Reset
REQ-029 While resetn=0, state SHALL go to IDLE and the round-robin pointer SHALL be set so requester 0 wins first.
REQ-030 While resetn=0, all ready, rvalid, s_rstrb and s_wmask outputs SHALL be 0, and rdata and s_addr SHALL be 0.
REQ-031 Reset asserted while in RDATA SHALL suppress the pending rvalid, and the read SHALL be lost.
REQ-032 In the first cycle after reset deasserts, a request SHALL be granted normally.

Configuration
REQ-033 With macro MEM_BUS_ARB_RR_EN defined, contention SHALL be resolved round-robin: the requester not granted most recently wins, and the pointer updates on every grant.
REQ-034 Without MEM_BUS_ARB_RR_EN, requester 0 SHALL always win contention (fixed priority), and the pointer logic SHALL be absent.

Structure
REQ-035 Package mem_bus_arb_pkg SHALL hold the state encoding (IDLE, RDATA), requester index constants (M0=0, M1=1) and the AW/DW defaults.
REQ-036 Sub-module mem_bus_arb_pick SHALL compute the grant from the two request bits and the last-grant pointer.
REQ-037 mem_bus_arb_pick SHALL be purely combinational.

Verification
REQ-038 Writes: m0 writes addr 0x10, data 0xDEADBEEF, wmask 1111, alone -> m0_ready=1 same cycle, s_wmask=1111, s_addr=0x10, state stays IDLE.
REQ-039 Read latency: m1 reads 0x20 with memory holding 0x12345678 -> m1_ready at cycle N; m1_rvalid=1 and m1_rdata=0x12345678 at N+1; no grant at N+1.
REQ-040 Contention (RR): both request reads continuously -> grant order m0, m1, m0, m1, each separated by an RDATA cycle. Without the macro -> m0 every grant and m1 starved.
REQ-041 Back-to-back writes: m0 and m1 both issue writes for 4 cycles with RR -> 4 consecutive grants alternating m0/m1, and no idle cycle between them.
REQ-042 Reset mid-read: resetn=0 in the RDATA cycle -> no rvalid is seen, all outputs are 0, and after release m0 wins a simultaneous request.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// mem_bus_arb_pkg -- shared types and constants for the two-requester memory arbiter.
//   state_t     : arbiter FSM encoding (IDLE, RDATA)
//   M0 / M1     : requester index constants (1-bit grant index)
//   AW_DEF/DW_DEF: default address / data widths
package mem_bus_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        RDATA = 1'b1
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

endpackage

// File: rtl/mem_bus_arb_pick.sv
// mem_bus_arb_pick -- combinational grant selection for two requesters.
//   req_i     in  2  request bits {m1, m0}
//   last_i    in  1  index granted most recently (only with MEM_BUS_ARB_RR_EN)
//   gnt_vld_o out 1  some requester is granted
//   gnt_idx_o out 1  index of the granted requester
// Build option: MEM_BUS_ARB_RR_EN selects round-robin on contention;
// otherwise requester 0 always wins contention.
module mem_bus_arb_pick
    import mem_bus_arb_pkg::*;
(
`ifdef MEM_BUS_ARB_RR_EN
    input  logic       last_i,
`endif
    input  logic [1:0] req_i,
    output logic       gnt_vld_o,
    output logic       gnt_idx_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        if (req_i == 2'b11) begin
`ifdef MEM_BUS_ARB_RR_EN
            // The requester that did not win last time goes first.
            gnt_idx_o = ~last_i;
`else
            gnt_idx_o = M0;
`endif
        end else begin
            // Single requester (or none): it wins regardless of history.
            gnt_idx_o = req_i[1] ? M1 : M0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter -- shares one memory port between two requesters.
//   clk, resetn                 clock, synchronous active-low reset
//   m{0,1}_addr/rstrb/wdata/wmask  requests (held until ready)
//   m{0,1}_ready                request accepted this cycle
//   m{0,1}_rdata/rvalid         read data, valid one cycle after the grant
//   s_addr/rstrb/wdata/wmask    shared memory port, driven only in a grant cycle
//   s_rdata                     memory read data, one cycle after s_rstrb
// Writes finish in the grant cycle; reads spend one RDATA cycle returning data.
// Build option: MEM_BUS_ARB_RR_EN enables round-robin arbitration.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_rstrb,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic            m0_ready,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_rvalid,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_rstrb,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_rvalid,
    output logic [AW-1:0]   s_addr,
    output logic            s_rstrb,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wmask,
    input  logic [DW-1:0]   s_rdata
);

    state_t     state_q, state_d;
    logic       idx_q, idx_d;        // requester owed read data in RDATA
    logic [1:0] req_idle;
    logic       gnt_vld, gnt_idx, gnt_rd;

`ifdef MEM_BUS_ARB_RR_EN
    logic       last_q, last_d;
`endif

    // Requests are only considered in IDLE; RDATA never grants.
    assign req_idle = {m1_rstrb | (|m1_wmask), m0_rstrb | (|m0_wmask)}
                    & {2{state_q == IDLE}};
    assign gnt_rd   = (gnt_idx == M1) ? m1_rstrb : m0_rstrb;

    mem_bus_arb_pick u_pick (
`ifdef MEM_BUS_ARB_RR_EN
        .last_i    (last_q),
`endif
        .req_i     (req_idle),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= M0;
`ifdef MEM_BUS_ARB_RR_EN
            last_q  <= M1;   // so M0 wins the first contention
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
`ifdef MEM_BUS_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef MEM_BUS_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
`ifdef MEM_BUS_ARB_RR_EN
                    last_d = gnt_idx;
`endif
                    // A combined read+write takes the read path.
                    if (gnt_rd) begin
                        state_d = RDATA;
                        idx_d   = gnt_idx;
                    end
                end
            end
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; everything is forced to 0 while reset is held, which also
    // drops an rvalid that was due in the RDATA cycle.
    always_comb begin
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        s_addr    = '0;
        s_rstrb   = 1'b0;
        s_wdata   = '0;
        s_wmask   = '0;
        if (resetn) begin
            if (gnt_vld) begin
                if (gnt_idx == M1) begin
                    s_addr   = m1_addr;
                    s_rstrb  = m1_rstrb;
                    s_wdata  = m1_wdata;
                    s_wmask  = m1_wmask;
                    m1_ready = 1'b1;
                end else begin
                    s_addr   = m0_addr;
                    s_rstrb  = m0_rstrb;
                    s_wdata  = m0_wdata;
                    s_wmask  = m0_wmask;
                    m0_ready = 1'b1;
                end
            end
            if (state_q == RDATA) begin
                if (idx_q == M1) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = s_rdata;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = s_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter -- directed scenarios then random traffic, checked each
// cycle against a transaction-level model (pending requests, one data cycle
// after each read, a word-array memory image).
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic          m0_rstrb, m1_rstrb, s_rstrb;
    logic [DW-1:0] m0_wdata, m1_wdata, s_wdata;
    logic [BW-1:0] m0_wmask, m1_wmask, s_wmask;
    logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [DW-1:0] s_rdata = '0;

    mem_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .s_addr(s_addr), .s_rstrb(s_rstrb), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_rdata(s_rdata)
    );

    // Memory attached to the shared port: read returns the pre-write word.
    logic [DW-1:0] mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (s_rstrb) s_rdata <= mem[s_addr[5:2]];
        for (int b = 0; b < BW; b++)
            if (s_wmask[b]) mem[s_addr[5:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end

    typedef struct {
        bit            act;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] wmask;
        logic          rstrb;
    } rq_t;

    rq_t           rq [2];
    logic [DW-1:0] ref_mem [16] = '{default: '0};
    bit            m_rd_pend;
    int            m_rd_who;
    logic [DW-1:0] m_rd_val;
    int            m_last;
    int            total, bad;
    int            ocnt [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        m0_addr  = rq[0].act ? rq[0].addr  : '0;
        m0_rstrb = rq[0].act ? rq[0].rstrb : 1'b0;
        m0_wdata = rq[0].act ? rq[0].wdata : '0;
        m0_wmask = rq[0].act ? rq[0].wmask : '0;
        m1_addr  = rq[1].act ? rq[1].addr  : '0;
        m1_rstrb = rq[1].act ? rq[1].rstrb : 1'b0;
        m1_wdata = rq[1].act ? rq[1].wdata : '0;
        m1_wmask = rq[1].act ? rq[1].wmask : '0;
    endtask

    task automatic setreq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] m, input logic r);
        rq[i].act = 1'b1; rq[i].addr = a; rq[i].wdata = d; rq[i].wmask = m; rq[i].rstrb = r;
    endtask

    task automatic newreq(input int i);
        int kind;
        kind = $urandom_range(0, 2);
        setreq(i, AW'($urandom_range(0, 15)) << 2, DW'($urandom),
               (kind == 0) ? '0 : BW'($urandom_range(1, 15)), kind != 1);
    endtask

    // Contention winner: alternate under round-robin, else requester 0.
    function automatic int pick_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_BUS_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    // One clock: entered at posedge+1, checks mid-cycle, advances the model.
    task automatic cycle();
        int            win;
        bit            r [2];
        logic [1:0]    erdy, erv;
        logic [DW-1:0] erd [2];
        logic [AW-1:0] ea;
        logic          er;
        logic [DW-1:0] ed;
        logic [BW-1:0] em;
        drive();
        #4;
        for (int i = 0; i < 2; i++)
            r[i] = rq[i].act && (rq[i].rstrb || rq[i].wmask != '0);
        win = -1; erdy = '0; erv = '0; erd[0] = '0; erd[1] = '0;
        ea = '0; er = 1'b0; ed = '0; em = '0;
        if (resetn) begin
            if (m_rd_pend) begin
                erv[m_rd_who] = 1'b1;
                erd[m_rd_who] = m_rd_val;
            end else begin
                win = pick_winner(r[0], r[1]);
                if (win >= 0) begin
                    erdy[win] = 1'b1;
                    ea = rq[win].addr; er = rq[win].rstrb;
                    ed = rq[win].wdata; em = rq[win].wmask;
                end
            end
        end
        chk("m0_ready",  64'(m0_ready),  64'(erdy[0]));
        chk("m1_ready",  64'(m1_ready),  64'(erdy[1]));
        chk("m0_rvalid", 64'(m0_rvalid), 64'(erv[0]));
        chk("m1_rvalid", 64'(m1_rvalid), 64'(erv[1]));
        chk("m0_rdata",  64'(m0_rdata),  64'(erd[0]));
        chk("m1_rdata",  64'(m1_rdata),  64'(erd[1]));
        chk("s_addr",    64'(s_addr),    64'(ea));
        chk("s_rstrb",   64'(s_rstrb),   64'(er));
        chk("s_wdata",   64'(s_wdata),   64'(ed));
        chk("s_wmask",   64'(s_wmask),   64'(em));
        ocnt[0] += int'(m0_ready);
        ocnt[1] += int'(m1_ready);
        @(posedge clk);
        if (!resetn) begin
            m_rd_pend = 1'b0;
            m_last    = 1;
        end else if (m_rd_pend) begin
            m_rd_pend = 1'b0;
        end else if (win >= 0) begin
            m_last = win;
            if (rq[win].rstrb) begin
                m_rd_pend = 1'b1;
                m_rd_who  = win;
                m_rd_val  = ref_mem[rq[win].addr[5:2]];
            end
            for (int b = 0; b < BW; b++)
                if (rq[win].wmask[b])
                    ref_mem[rq[win].addr[5:2]][b*8 +: 8] = rq[win].wdata[b*8 +: 8];
            rq[win].act = 1'b0;
        end
        #1;
    endtask

    initial begin
        total = 0; bad = 0; ocnt[0] = 0; ocnt[1] = 0;
        m_rd_pend = 1'b0; m_rd_who = 0; m_rd_val = '0; m_last = 1;
        for (int i = 0; i < 2; i++) setreq(i, '0, '0, '0, 1'b0);
        rq[0].act = 1'b0; rq[1].act = 1'b0;
        drive();
        @(posedge clk); #1;

        // Reset with requests present: all outputs stay 0.
        setreq(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        setreq(1, 32'h20, 32'h0, 4'h0, 1'b1);
        repeat (3) cycle();
        rq[0].act = 1'b0; rq[1].act = 1'b0;
        resetn = 1'b1;

        // Lone write, then a write + read of 0x20.
        setreq(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        cycle();
        setreq(0, 32'h20, 32'h12345678, 4'hF, 1'b0);
        cycle();
        setreq(1, 32'h20, 32'h0, 4'h0, 1'b1);
        cycle();
        cycle();
        cycle();

        // Continuous read contention.
        ocnt[0] = 0; ocnt[1] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++)
                if (!rq[i].act) setreq(i, AW'(32'h10 + 4 * i), '0, '0, 1'b1);
            cycle();
        end
`ifdef MEM_BUS_ARB_RR_EN
        chk("contend_m0_grants", 64'(ocnt[0]), 64'd2);
        chk("contend_m1_grants", 64'(ocnt[1]), 64'd2);
`else
        chk("contend_m0_grants", 64'(ocnt[0]), 64'd4);
        chk("contend_m1_grants", 64'(ocnt[1]), 64'd0);
`endif
        rq[0].act = 1'b0; rq[1].act = 1'b0;

        // Back-to-back writes from both requesters.
        ocnt[0] = 0; ocnt[1] = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 2; i++)
                if (!rq[i].act) setreq(i, AW'(4 * (k + 8 * i)), DW'($urandom), 4'hF, 1'b0);
            cycle();
        end
        chk("b2b_total_grants", 64'(ocnt[0] + ocnt[1]), 64'd4);
`ifdef MEM_BUS_ARB_RR_EN
        chk("b2b_m0_grants", 64'(ocnt[0]), 64'd2);
`else
        chk("b2b_m0_grants", 64'(ocnt[0]), 64'd4);
`endif
        rq[0].act = 1'b0; rq[1].act = 1'b0;

        // Reset during the data cycle of a read.
        setreq(1, 32'h20, '0, '0, 1'b1);
        cycle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        ocnt[0] = 0; ocnt[1] = 0;
        setreq(0, 32'h10, '0, '0, 1'b1);
        setreq(1, 32'h20, '0, '0, 1'b1);
        cycle();
        chk("post_reset_m0_wins", 64'(ocnt[0]), 64'd1);
        chk("post_reset_m1_waits", 64'(ocnt[1]), 64'd0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 2; i++)
                if (!rq[i].act && $urandom_range(0, 2) != 0) newreq(i);
            resetn = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
